snitch_mem_responder: RTL and testbench

//  Memory-side responder for the Snitch test-harness data port (mem_valid/mem_ready, 64-bit).

---
 rtl/snitch_mem_pkg.sv | 30 +++
 rtl/snitch_mem_array.sv | 39 +++
 rtl/snitch_mem_responder.sv | 157 +++++++++++++++
 tb/tb_snitch_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_mem_pkg.sv
// Shared types and widths for the Snitch memory-side responder.
package snitch_mem_pkg;

    localparam int unsigned WordBits = 64;
    localparam int unsigned StrbBits = 8;
    localparam int unsigned AddrBits = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Replace the bytes of old selected by wstrb with the matching bytes of wdata.
    function automatic logic [WordBits-1:0] byte_merge(
        input logic [WordBits-1:0] old,
        input logic [WordBits-1:0] wdata,
        input logic [StrbBits-1:0] wstrb
    );
        logic [WordBits-1:0] merged;
        merged = old;
        for (int b = 0; b < StrbBits; b++) begin
            if (wstrb[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/snitch_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset; benches reach the words through u_array.mem.
module snitch_mem_array
    import snitch_mem_pkg::*;
#(
    parameter int unsigned NumWords = 1024,
    localparam int unsigned IdxBits = $clog2(NumWords)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [IdxBits-1:0]  i_idx,
    input  logic [WordBits-1:0] i_wdata,
    input  logic [StrbBits-1:0] i_be,
    output logic [WordBits-1:0] o_rdata
);

    logic [WordBits-1:0] mem [NumWords];
    logic [WordBits-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < StrbBits; b++) begin
                if (i_be[b]) begin
                    mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/snitch_mem_responder.sv
// Memory-side responder for the Snitch harness data port: one request in flight,
// programmable latency, byte-strobed writes and a single-cycle acknowledge.
module snitch_mem_responder
    import snitch_mem_pkg::*;
#(
    parameter int unsigned          NumWords = 1024,
    parameter int unsigned          Latency  = 1,
    parameter logic [AddrBits-1:0]  BaseAddr = 32'h0001_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mem_valid_i,
    input  logic [AddrBits-1:0] mem_addr_i,
    input  logic                mem_write_i,
    input  logic [WordBits-1:0] mem_wdata_i,
    input  logic [StrbBits-1:0] mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [WordBits-1:0] mem_rdata_o,
    input  logic                stall_i,
    output logic                oob_o,
    output logic [31:0]         req_count_o
);

    localparam int unsigned        IdxBits     = $clog2(NumWords);
    localparam logic [AddrBits-1:0] SpanBytes  = AddrBits'(NumWords * 8);
    // The IDLE cycle that accepts the request counts as the first latency cycle.
    localparam logic               SingleCycle = (Latency == 1);
    localparam logic [7:0]         WaitLoad    = (Latency > 1) ? 8'(Latency - 2) : 8'd0;

    state_e r_state;
    state_e w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_access;

    logic [AddrBits-1:0] r_addr;
    logic                r_write;
    logic [WordBits-1:0] r_wdata;
    logic [StrbBits-1:0] r_wstrb;

    logic                r_ready;
    logic                r_oob;
    logic                r_rd_ok;
    logic [31:0]         r_count;

    logic [AddrBits-1:0] w_req_addr;
    logic                w_req_write;
    logic [WordBits-1:0] w_req_wdata;
    logic [StrbBits-1:0] w_req_wstrb;
    logic [AddrBits-1:0] w_off;
    logic                w_in_range;
    logic [IdxBits-1:0]  w_idx;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [WordBits-1:0] w_ram_rdata;
    logic                w_unused_off;

    // With Latency=1 the access happens in the accepting cycle, before the latch has loaded.
    assign w_req_addr  = (r_state == IDLE) ? mem_addr_i  : r_addr;
    assign w_req_write = (r_state == IDLE) ? mem_write_i : r_write;
    assign w_req_wdata = (r_state == IDLE) ? mem_wdata_i : r_wdata;
    assign w_req_wstrb = (r_state == IDLE) ? mem_wstrb_i : r_wstrb;

    // Offset-based compare avoids overflow of BaseAddr + span at the top of the map.
    assign w_off        = w_req_addr - BaseAddr;
    assign w_in_range   = (w_req_addr >= BaseAddr) && (w_off < SpanBytes);
    assign w_idx        = w_off[IdxBits+2:3];
    assign w_unused_off = ^{w_off[AddrBits-1:IdxBits+3], w_off[2:0]};

    assign w_ram_we = w_access && w_req_write && w_in_range;
    assign w_ram_re = w_access && !w_req_write && w_in_range;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_access     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_valid_i) begin
                    if (SingleCycle && !stall_i) begin
                        w_access     = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_cnt_next   = WaitLoad;
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_next = r_cnt - 8'd1;
                end else if (!stall_i) begin
                    w_access     = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_ready <= 1'b0;
            r_oob   <= 1'b0;
            r_rd_ok <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ready <= w_access;
            r_oob   <= w_access && !w_in_range;
            r_rd_ok <= w_ram_re;
            if (r_state == RESP) begin
                r_count <= r_count + 32'd1;
            end
            if (r_state == IDLE && mem_valid_i) begin
                r_addr  <= mem_addr_i;
                r_write <= mem_write_i;
                r_wdata <= mem_wdata_i;
                r_wstrb <= mem_wstrb_i;
            end
        end
    end

    snitch_mem_array #(
        .NumWords (NumWords)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_idx   (w_idx),
        .i_wdata (w_req_wdata),
        .i_be    (w_req_wstrb),
        .o_rdata (w_ram_rdata)
    );

    // Read data is gated so the port reads zero outside a successful read response.
    assign mem_rdata_o = {WordBits{r_rd_ok}} & w_ram_rdata;
    assign mem_ready_o = r_ready;
    assign oob_o       = r_oob;
    assign req_count_o = r_count;

    a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state != IDLE) |-> mem_valid_i);

endmodule

// File: tb/tb_snitch_mem_responder.sv
// Directed bench: three responders (Latency 1, 4, 3) sharing one clock, separate stimulus.
module tb_snitch_mem_responder;

    logic        clk;
    logic        rst_n   [3];
    logic        valid_s [3];
    logic [31:0] addr_s  [3];
    logic        write_s [3];
    logic [63:0] wdata_s [3];
    logic [7:0]  wstrb_s [3];
    logic        stall_s [3];
    logic        ready_s [3];
    logic [63:0] rdata_s [3];
    logic        oob_s   [3];
    logic [31:0] count_s [3];

    int vectors    = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snitch_mem_responder #(.Latency(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .mem_valid_i(valid_s[0]), .mem_addr_i(addr_s[0]),
        .mem_write_i(write_s[0]), .mem_wdata_i(wdata_s[0]), .mem_wstrb_i(wstrb_s[0]),
        .mem_ready_o(ready_s[0]), .mem_rdata_o(rdata_s[0]), .stall_i(stall_s[0]),
        .oob_o(oob_s[0]), .req_count_o(count_s[0])
    );

    snitch_mem_responder #(.Latency(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .mem_valid_i(valid_s[1]), .mem_addr_i(addr_s[1]),
        .mem_write_i(write_s[1]), .mem_wdata_i(wdata_s[1]), .mem_wstrb_i(wstrb_s[1]),
        .mem_ready_o(ready_s[1]), .mem_rdata_o(rdata_s[1]), .stall_i(stall_s[1]),
        .oob_o(oob_s[1]), .req_count_o(count_s[1])
    );

    snitch_mem_responder #(.Latency(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .mem_valid_i(valid_s[2]), .mem_addr_i(addr_s[2]),
        .mem_write_i(write_s[2]), .mem_wdata_i(wdata_s[2]), .mem_wstrb_i(wstrb_s[2]),
        .mem_ready_o(ready_s[2]), .mem_rdata_o(rdata_s[2]), .stall_i(stall_s[2]),
        .oob_o(oob_s[2]), .req_count_o(count_s[2])
    );

    // Inputs are driven and registered outputs observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request starting in the current cycle (cycle 0) and return what was seen.
    // lat is the cycle index at which ready appeared, or -1 if it never did.
    task automatic xact(input int k, input logic wr, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] ws, input logic [15:0] stall_mask,
                        output int lat, output logic [63:0] rd, output logic ob,
                        output logic rdy_after, output logic [31:0] cnt_after);
        valid_s[k] = 1'b1;
        write_s[k] = wr;
        addr_s[k]  = a;
        wdata_s[k] = wd;
        wstrb_s[k] = ws;
        stall_s[k] = stall_mask[0];
        lat = -1;
        rd  = '0;
        ob  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            stall_s[k] = (c < 16) ? stall_mask[c] : 1'b0;
            if (ready_s[k]) begin
                lat = c;
                rd  = rdata_s[k];
                ob  = oob_s[k];
                break;
            end
        end
        step();
        valid_s[k] = 1'b0;
        stall_s[k] = 1'b0;
        rdy_after  = ready_s[k];
        cnt_after  = count_s[k];
        $display("dut%0d %s addr=%h wdata=%h wstrb=%h -> lat=%0d rdata=%h oob=%b count=%0d",
                 k, wr ? "WR" : "RD", a, wd, ws, lat, rd, ob, cnt_after);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; valid_s[k] = 1'b0; addr_s[k] = '0; write_s[k] = 1'b0;
            wdata_s[k] = '0; wstrb_s[k] = '0; stall_s[k] = 1'b0;
        end
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            vectors += 4;
            if (ready_s[k] !== 1'b0) begin miscompares++; $display("FAIL reset_ready dut%0d: got %b expected 0", k, ready_s[k]); end
            if (rdata_s[k] !== 64'd0) begin miscompares++; $display("FAIL reset_rdata dut%0d: got %h expected 0", k, rdata_s[k]); end
            if (oob_s[k] !== 1'b0) begin miscompares++; $display("FAIL reset_oob dut%0d: got %b expected 0", k, oob_s[k]); end
            if (count_s[k] !== 32'd0) begin miscompares++; $display("FAIL reset_count dut%0d: got %0d expected 0", k, count_s[k]); end
            rst_n[k] = 1'b1;
        end
        step();
    endtask

    task automatic test_latency1_read();
        int lat; logic [63:0] rd; logic ob; logic ra; logic [31:0] cnt;
        // Preload word 0, then reset: RAM keeps its contents while the counter clears.
        xact(0, 1'b1, 32'h0001_0000, 64'h1122334455667788, 8'hFF, 16'h0, lat, rd, ob, ra, cnt);
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        step();
        xact(0, 1'b0, 32'h0001_0000, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 5;
        if (lat != 1) begin miscompares++; $display("FAIL l1_read_latency: got %0d expected 1", lat); end
        if (rd !== 64'h1122334455667788) begin miscompares++; $display("FAIL l1_read_rdata: got %h expected 1122334455667788", rd); end
        if (ob !== 1'b0) begin miscompares++; $display("FAIL l1_read_oob: got %b expected 0", ob); end
        if (ra !== 1'b0) begin miscompares++; $display("FAIL l1_read_ready_width: got %b expected 0", ra); end
        if (cnt !== 32'd1) begin miscompares++; $display("FAIL l1_read_count: got %0d expected 1", cnt); end
    endtask

    task automatic test_byte_strobe();
        int lat; logic [63:0] rd; logic ob; logic ra; logic [31:0] cnt;
        xact(0, 1'b1, 32'h0001_0008, 64'h0, 8'hFF, 16'h0, lat, rd, ob, ra, cnt);
        xact(0, 1'b1, 32'h0001_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 3;
        if (lat != 1) begin miscompares++; $display("FAIL strb_write_latency: got %0d expected 1", lat); end
        if (rd !== 64'd0) begin miscompares++; $display("FAIL strb_write_rdata: got %h expected 0", rd); end
        if (ob !== 1'b0) begin miscompares++; $display("FAIL strb_write_oob: got %b expected 0", ob); end
        xact(0, 1'b0, 32'h0001_0008, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (rd !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL strb_read_rdata: got %h expected 00000000ffffffff", rd); end
        // Zero strobe: acknowledged but the word stays as it was.
        xact(0, 1'b1, 32'h0001_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (lat != 1) begin miscompares++; $display("FAIL strb0_ack_latency: got %0d expected 1", lat); end
        xact(0, 1'b0, 32'h0001_0008, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 2;
        if (rd !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL strb0_read_rdata: got %h expected 00000000ffffffff", rd); end
        if (cnt !== 32'd6) begin miscompares++; $display("FAIL strb_count: got %0d expected 6", cnt); end
    endtask

    task automatic test_back_to_back();
        // Cycle 0: write idx2, valid then stays high for a read of idx2 and a read of idx0.
        valid_s[0] = 1'b1; write_s[0] = 1'b1; addr_s[0] = 32'h0001_0010;
        wdata_s[0] = 64'hCAFE_F00D_1234_5678; wstrb_s[0] = 8'hFF;
        step();
        vectors += 2;
        if (ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c1: got %b expected 1", ready_s[0]); end
        if (rdata_s[0] !== 64'd0) begin miscompares++; $display("FAIL b2b_wr_rdata_c1: got %h expected 0", rdata_s[0]); end
        step();
        vectors += 1;
        if (ready_s[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_c2: got %b expected 0", ready_s[0]); end
        write_s[0] = 1'b0; addr_s[0] = 32'h0001_0010;
        step();
        vectors += 2;
        if (ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c3: got %b expected 1", ready_s[0]); end
        if (rdata_s[0] !== 64'hCAFE_F00D_1234_5678) begin miscompares++; $display("FAIL b2b_hazard_rdata_c3: got %h expected cafef00d12345678", rdata_s[0]); end
        step();
        vectors += 2;
        if (ready_s[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_c4: got %b expected 0", ready_s[0]); end
        if (rdata_s[0] !== 64'd0) begin miscompares++; $display("FAIL b2b_rdata_idle_c4: got %h expected 0", rdata_s[0]); end
        addr_s[0] = 32'h0001_0000;
        step();
        vectors += 2;
        if (ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c5: got %b expected 1", ready_s[0]); end
        if (rdata_s[0] !== 64'h1122334455667788) begin miscompares++; $display("FAIL b2b_rdata_c5: got %h expected 1122334455667788", rdata_s[0]); end
        step();
        valid_s[0] = 1'b0;
        vectors += 2;
        if (ready_s[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_c6: got %b expected 0", ready_s[0]); end
        if (count_s[0] !== 32'd9) begin miscompares++; $display("FAIL b2b_count_c6: got %0d expected 9", count_s[0]); end
        $display("dut0 back-to-back WR 00010010, RD 00010010, RD 00010000 -> count=%0d", count_s[0]);
    endtask

    task automatic test_out_of_range();
        int lat; logic [63:0] rd; logic ob; logic ra; logic [31:0] cnt;
        logic [63:0] word;
        xact(0, 1'b0, 32'h0000_FFF8, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 3;
        if (lat != 1) begin miscompares++; $display("FAIL oob_low_latency: got %0d expected 1", lat); end
        if (rd !== 64'd0) begin miscompares++; $display("FAIL oob_low_rdata: got %h expected 0", rd); end
        if (ob !== 1'b1) begin miscompares++; $display("FAIL oob_low_flag: got %b expected 1", ob); end
        xact(0, 1'b0, 32'h0001_2000, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 2;
        if (rd !== 64'd0) begin miscompares++; $display("FAIL oob_high_rdata: got %h expected 0", rd); end
        if (ob !== 1'b1) begin miscompares++; $display("FAIL oob_high_flag: got %b expected 1", ob); end
        // 0x0001_2000 would alias word 0 if the index were simply truncated.
        xact(0, 1'b1, 32'h0001_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (ob !== 1'b1) begin miscompares++; $display("FAIL oob_write_flag: got %b expected 1", ob); end
        word = dut0.u_array.mem[0];
        vectors += 1;
        if (word !== 64'h1122334455667788) begin miscompares++; $display("FAIL oob_write_word0: got %h expected 1122334455667788", word); end
        word = dut0.u_array.mem[1];
        vectors += 1;
        if (word !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL oob_write_word1: got %h expected 00000000ffffffff", word); end
        word = dut0.u_array.mem[2];
        vectors += 1;
        if (word !== 64'hCAFE_F00D_1234_5678) begin miscompares++; $display("FAIL oob_write_word2: got %h expected cafef00d12345678", word); end
        xact(0, 1'b0, 32'h0001_1FF8, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (ob !== 1'b0) begin miscompares++; $display("FAIL last_word_oob: got %b expected 0", ob); end
    endtask

    task automatic test_latency4_stall();
        int lat; logic [63:0] rd; logic ob; logic ra; logic [31:0] cnt;
        xact(1, 1'b1, 32'h0001_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (lat != 4) begin miscompares++; $display("FAIL l4_write_latency: got %0d expected 4", lat); end
        // Stall in cycles 2..4: cycle 2 is still counting, cycles 3 and 4 each add one.
        xact(1, 1'b0, 32'h0001_0000, 64'h0, 8'h00, 16'b0000_0000_0001_1100, lat, rd, ob, ra, cnt);
        vectors += 3;
        if (lat != 6) begin miscompares++; $display("FAIL l4_stall_latency: got %0d expected 6", lat); end
        if (rd !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL l4_stall_rdata: got %h expected 0123456789abcdef", rd); end
        if (ra !== 1'b0) begin miscompares++; $display("FAIL l4_ready_width: got %b expected 0", ra); end
        xact(1, 1'b0, 32'h0001_0000, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 2;
        if (lat != 4) begin miscompares++; $display("FAIL l4_read_latency: got %0d expected 4", lat); end
        if (cnt !== 32'd3) begin miscompares++; $display("FAIL l4_count: got %0d expected 3", cnt); end
    endtask

    task automatic test_reset_midop();
        int lat; logic [63:0] rd; logic ob; logic ra; logic [31:0] cnt;
        logic seen_ready;
        logic [63:0] word;
        xact(2, 1'b1, 32'h0001_0010, 64'h5555_6666_7777_8888, 8'hFF, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 1;
        if (lat != 3) begin miscompares++; $display("FAIL l3_write_latency: got %0d expected 3", lat); end
        valid_s[2] = 1'b1; write_s[2] = 1'b1; addr_s[2] = 32'h0001_0010;
        wdata_s[2] = 64'h9999_AAAA_BBBB_CCCC; wstrb_s[2] = 8'hFF;
        step();
        rst_n[2] = 1'b0;
        valid_s[2] = 1'b0;
        #1;
        seen_ready = ready_s[2];
        step();
        rst_n[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ready_s[2]) seen_ready = 1'b1;
        end
        vectors += 4;
        if (seen_ready !== 1'b0) begin miscompares++; $display("FAIL midop_no_ready: got %b expected 0", seen_ready); end
        if (rdata_s[2] !== 64'd0) begin miscompares++; $display("FAIL midop_rdata: got %h expected 0", rdata_s[2]); end
        if (oob_s[2] !== 1'b0) begin miscompares++; $display("FAIL midop_oob: got %b expected 0", oob_s[2]); end
        if (count_s[2] !== 32'd0) begin miscompares++; $display("FAIL midop_count: got %0d expected 0", count_s[2]); end
        word = dut2.u_array.mem[2];
        vectors += 1;
        if (word !== 64'h5555_6666_7777_8888) begin miscompares++; $display("FAIL midop_word: got %h expected 5555666677778888", word); end
        $display("dut2 WR 00010010 aborted by reset -> ready_seen=%b count=%0d", seen_ready, count_s[2]);
        xact(2, 1'b0, 32'h0001_0010, 64'h0, 8'h00, 16'h0, lat, rd, ob, ra, cnt);
        vectors += 3;
        if (lat != 3) begin miscompares++; $display("FAIL midop_read_latency: got %0d expected 3", lat); end
        if (rd !== 64'h5555_6666_7777_8888) begin miscompares++; $display("FAIL midop_read_rdata: got %h expected 5555666677778888", rd); end
        if (cnt !== 32'd1) begin miscompares++; $display("FAIL midop_read_count: got %0d expected 1", cnt); end
    endtask

    initial begin
        test_reset();
        test_latency1_read();
        test_byte_strobe();
        test_back_to_back();
        test_out_of_range();
        test_latency4_stall();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
